// File: rtl/arb2to1_pkg.sv
// arb2to1_pkg: shared state, grant and select encodings for the 2:1 stream arbiter and its mux stage
package arb2to1_pkg;
  typedef enum logic {EMPTY, FULL} state_t;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_A, GRANT_B} grant_t;
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/arb2to1_stream_mux.sv
// arb2to1_stream_mux: WIDTH-bit 2:1 selector, sel=SEL_A picks a, otherwise b
module arb2to1_stream_mux
  import arb2to1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = (sel == SEL_A) ? a : b;
endmodule

// File: rtl/arb2to1_stream.sv
// arb2to1_stream: round-robin valid/ready arbiter of two streams into a single-entry output register.
// Define ARB2TO1_LOCK_EN to hold the grant on one source until its beat with last=1.
module arb2to1_stream
  import arb2to1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
`ifdef ARB2TO1_LOCK_EN
  input  logic             a_last,
  input  logic             b_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);
  state_t           state_q, state_d;
  grant_t           grant;
  logic             last_grant_q, last_grant_d;
  logic             out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, mux_y;
  logic             load_en, xfer, sel;
`ifdef ARB2TO1_LOCK_EN
  logic             lock_q, lock_d, lock_src_q, lock_src_d, out_last_q, out_last_d, beat_last;
`endif

  arb2to1_stream_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (sel),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_y)
  );

  always_comb begin
    grant = (a_valid && b_valid) ? ((last_grant_q == SEL_B) ? GRANT_A : GRANT_B)
          : a_valid ? GRANT_A : b_valid ? GRANT_B : GRANT_NONE;
`ifdef ARB2TO1_LOCK_EN
    if (lock_q) grant = (lock_src_q == SEL_A) ? (a_valid ? GRANT_A : GRANT_NONE)
                                              : (b_valid ? GRANT_B : GRANT_NONE);
`endif
    load_en    = (state_q == EMPTY) || out_ready;
    xfer       = load_en && (grant != GRANT_NONE);
    sel        = (grant == GRANT_A) ? SEL_A : SEL_B;
    a_ready    = load_en && (grant == GRANT_A);
    b_ready    = load_en && (grant == GRANT_B);
    state_d    = xfer ? FULL : (out_ready ? EMPTY : state_q);
    out_data_d = xfer ? mux_y : out_data_q;
    out_sel_d  = xfer ? sel : out_sel_q;
`ifdef ARB2TO1_LOCK_EN
    beat_last    = (sel == SEL_A) ? a_last : b_last;
    lock_d       = xfer ? !beat_last : lock_q;
    lock_src_d   = xfer ? sel : lock_src_q;
    out_last_d   = xfer ? beat_last : out_last_q;
    // priority only moves once a whole packet has gone through
    last_grant_d = (xfer && beat_last) ? sel : last_grant_q;
`else
    last_grant_d = xfer ? sel : last_grant_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= SEL_B;
      last_grant_q <= SEL_B;
`ifdef ARB2TO1_LOCK_EN
      lock_q       <= 1'b0;
      lock_src_q   <= SEL_B;
      out_last_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
`ifdef ARB2TO1_LOCK_EN
      lock_q       <= lock_d;
      lock_src_q   <= lock_src_d;
      out_last_q   <= out_last_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef ARB2TO1_LOCK_EN
  assign out_last  = out_last_q;
`endif
endmodule
